// File: rtl/step_dir_decoder.sv
// step_dir_decoder
//   Receive-side decoder for one stepper axis. Synchronizes the step, dir and
//   enable_n pins, counts accepted step rising edges into a signed position,
//   measures the period between accepted edges and flags timing violations.
//
//   Optional feature macro: STEP_DECODER_SOFT_LIMIT_EN
//     adds parameters POS_MIN / POS_MAX and the sticky output limit_hit.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     step_in             step pin, rising edge = one step
//     dir_in              direction pin, 1 = +1, 0 = -1
//     enable_n_in         active-low driver enable pin
//     clear_pos           zero the position (applied before a same-cycle step)
//     clear_err           clear the sticky error flags (a same-cycle set wins)
//     position            signed step count, wraps modulo 2^POS_W
//     step_period         cycles between the last two accepted rising edges
//     period_valid        one-cycle strobe when step_period updates
//     moving              steps are arriving (drops after IDLE_TIMEOUT idle cycles)
//     err_pulse_width     sticky, step high time shorter than MIN_HIGH
//     err_dir_setup       sticky, dir changed less than DIR_SETUP cycles before a step
//     err_step_disabled   sticky, step edge seen while the driver was disabled
//     limit_hit           sticky, accepted step left [POS_MIN, POS_MAX] (feature only)
//
//   state      | meaning
//   WAIT_FIRST | no reference edge yet, next accepted rise starts period timing
//   RUN        | steps arriving, period counter running, idle timer armed
module step_dir_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_HIGH     = 4,
  parameter int DIR_SETUP    = 2,
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int POS_W        = 32,
`ifdef STEP_DECODER_SOFT_LIMIT_EN
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 200000,
`endif
  parameter int PERIOD_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_in,
  input  logic                dir_in,
  input  logic                enable_n_in,
  input  logic                clear_pos,
  input  logic                clear_err,
  output logic [POS_W-1:0]    position,
  output logic [PERIOD_W-1:0] step_period,
  output logic                period_valid,
  output logic                moving,
  output logic                err_pulse_width,
  output logic                err_dir_setup,
`ifdef STEP_DECODER_SOFT_LIMIT_EN
  output logic                limit_hit,
`endif
  output logic                err_step_disabled
);

  localparam int HIGH_W = (MIN_HIGH < 1) ? 1 : $clog2(MIN_HIGH + 1);
  localparam int DIR_W  = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam int IDLE_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);

  localparam logic [HIGH_W-1:0] HIGH_SAT  = HIGH_W'(MIN_HIGH);
  localparam logic [DIR_W-1:0]  DIR_SAT   = DIR_W'(DIR_SETUP);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {WAIT_FIRST = 1'b0, RUN = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
  logic [SYNC_STAGES-1:0] dir_sync_q, dir_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic                   step_prev_q, step_prev_d;
  logic                   dir_prev_q, dir_prev_d;
  logic [HIGH_W-1:0]      high_q, high_d;
  logic [DIR_W-1:0]       stable_q, stable_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic [PERIOD_W-1:0]    step_period_q, step_period_d;
  logic                   period_valid_q, period_valid_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic                   err_pw_q, err_pw_d;
  logic                   err_ds_q, err_ds_d;
  logic                   err_dis_q, err_dis_d;
  state_t                 state_q, state_d;

  logic                   s_step, s_dir, s_en;
  logic                   rise, fall, accept, dir_chg;
  logic [POS_W-1:0]       pos_base, pos_step;
  logic [PERIOD_W-1:0]    period_inc;

  assign s_step  = step_sync_q[SYNC_STAGES-1];
  assign s_dir   = dir_sync_q[SYNC_STAGES-1];
  assign s_en    = en_sync_q[SYNC_STAGES-1];
  assign rise    = s_step & ~step_prev_q;
  assign fall    = ~s_step & step_prev_q;
  assign accept  = rise & ~s_en;
  assign dir_chg = s_dir ^ dir_prev_q;

  // clear_pos is applied before a coincident step
  assign pos_base   = clear_pos ? '0 : pos_q;
  assign pos_step   = s_dir ? (pos_base + POS_W'(1)) : (pos_base - POS_W'(1));
  assign period_inc = (&period_q) ? period_q : (period_q + PERIOD_W'(1));

`ifdef STEP_DECODER_SOFT_LIMIT_EN
  localparam logic signed [POS_W-1:0] LIM_LO = POS_W'(POS_MIN);
  localparam logic signed [POS_W-1:0] LIM_HI = POS_W'(POS_MAX);
  logic limit_q, limit_d;

  always_comb begin
    limit_d = limit_q & ~clear_err;
    if (accept && (($signed(pos_step) < LIM_LO) || ($signed(pos_step) > LIM_HI)))
      limit_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) limit_q <= 1'b0;
    else     limit_q <= limit_d;
  end

  assign limit_hit = limit_q;
`endif

  always_comb begin
    step_sync_d    = {step_sync_q[SYNC_STAGES-2:0], step_in};
    dir_sync_d     = {dir_sync_q[SYNC_STAGES-2:0], dir_in};
    en_sync_d      = {en_sync_q[SYNC_STAGES-2:0], enable_n_in};
    step_prev_d    = s_step;
    dir_prev_d     = s_dir;
    high_d         = high_q;
    stable_d       = stable_q;
    idle_d         = idle_q;
    period_d       = period_q;
    step_period_d  = step_period_q;
    period_valid_d = 1'b0;
    pos_d          = accept ? pos_step : pos_base;
    state_d        = state_q;

    // high_q counts high cycles including the rise cycle
    if (rise)
      high_d = HIGH_W'(1);
    else if (s_step && (high_q != HIGH_SAT))
      high_d = high_q + HIGH_W'(1);

    if (dir_chg)
      stable_d = '0;
    else if (stable_q != DIR_SAT)
      stable_d = stable_q + DIR_W'(1);

    // set wins over a coincident clear_err
    err_pw_d  = (err_pw_q & ~clear_err) | (fall & (high_q < HIGH_SAT));
    // a dir change seen in the rise cycle itself also violates setup
    err_ds_d  = (err_ds_q & ~clear_err) | (accept & (dir_chg | (stable_q < DIR_SAT)));
    err_dis_d = (err_dis_q & ~clear_err) | (rise & s_en);

    unique case (state_q)
      WAIT_FIRST: begin
        if (accept) begin
          period_d = '0;
          idle_d   = IDLE_LOAD;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          step_period_d  = period_inc;
          period_valid_d = 1'b1;
          period_d       = '0;
          idle_d         = IDLE_LOAD;
        end else begin
          period_d = period_inc;
          if (idle_q == '0)
            state_d = WAIT_FIRST;
          else
            idle_d = idle_q - IDLE_W'(1);
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync_q    <= '0;
      dir_sync_q     <= '0;
      en_sync_q      <= '0;
      step_prev_q    <= 1'b0;
      dir_prev_q     <= 1'b0;
      high_q         <= '0;
      stable_q       <= '0;
      idle_q         <= '0;
      period_q       <= '0;
      step_period_q  <= '0;
      period_valid_q <= 1'b0;
      pos_q          <= '0;
      err_pw_q       <= 1'b0;
      err_ds_q       <= 1'b0;
      err_dis_q      <= 1'b0;
      state_q        <= WAIT_FIRST;
    end else begin
      step_sync_q    <= step_sync_d;
      dir_sync_q     <= dir_sync_d;
      en_sync_q      <= en_sync_d;
      step_prev_q    <= step_prev_d;
      dir_prev_q     <= dir_prev_d;
      high_q         <= high_d;
      stable_q       <= stable_d;
      idle_q         <= idle_d;
      period_q       <= period_d;
      step_period_q  <= step_period_d;
      period_valid_q <= period_valid_d;
      pos_q          <= pos_d;
      err_pw_q       <= err_pw_d;
      err_ds_q       <= err_ds_d;
      err_dis_q      <= err_dis_d;
      state_q        <= state_d;
    end
  end

  assign position          = pos_q;
  assign step_period       = step_period_q;
  assign period_valid      = period_valid_q;
  assign moving            = (state_q == RUN);
  assign err_pulse_width   = err_pw_q;
  assign err_dir_setup     = err_ds_q;
  assign err_step_disabled = err_dis_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
module tb_step_dir_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_in = 1'b0;
  logic        dir_in = 1'b0;
  logic        enable_n_in = 1'b0;
  logic        clear_pos = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] position;
  logic [31:0] step_period;
  logic        period_valid;
  logic        moving;
  logic        err_pulse_width;
  logic        err_dir_setup;
  logic        err_step_disabled;
`ifdef STEP_DECODER_SOFT_LIMIT_EN
  logic        limit_hit;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  bit chk_period = 1'b0;
  int exp_period = 0;

  step_dir_decoder #(
    .SYNC_STAGES (2),
    .MIN_HIGH    (4),
    .DIR_SETUP   (2),
    .IDLE_TIMEOUT(50),
    .POS_W       (32),
    .PERIOD_W    (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .step_in          (step_in),
    .dir_in           (dir_in),
    .enable_n_in      (enable_n_in),
    .clear_pos        (clear_pos),
    .clear_err        (clear_err),
    .position         (position),
    .step_period      (step_period),
    .period_valid     (period_valid),
    .moving           (moving),
    .err_pulse_width  (err_pulse_width),
    .err_dir_setup    (err_dir_setup),
`ifdef STEP_DECODER_SOFT_LIMIT_EN
    .limit_hit        (limit_hit),
`endif
    .err_step_disabled(err_step_disabled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      valid_cnt++;
      if (chk_period) check("step_period on strobe", step_period, 32'(exp_period));
    end
  end

  task automatic pulse(input int high, input int low);
    step_in = 1'b1;
    repeat (high) @(negedge clk);
    step_in = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step_in = 1'b0;
    clear_pos = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " position"}, position, 32'd0);
    check({tag, " step_period"}, step_period, 32'd0);
    check({tag, " period_valid"}, 32'(period_valid), 32'd0);
    check({tag, " moving"}, 32'(moving), 32'd0);
    check({tag, " err_pulse_width"}, 32'(err_pulse_width), 32'd0);
    check({tag, " err_dir_setup"}, 32'(err_dir_setup), 32'd0);
    check({tag, " err_step_disabled"}, 32'(err_step_disabled), 32'd0);
  endtask

  typedef struct {
    int   n;
    logic dir;
    int   high;
    int   per;
    logic en_n;
    int   exp_pos;
    int   exp_valids;
    logic exp_pw;
    logic exp_dis;
    logic exp_mov;
  } vec_t;

  vec_t vec[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    int mov_cnt;

    vec[0] = '{10, 1'b1, 5, 20, 1'b0,  10, 9, 1'b0, 1'b0, 1'b1};
    vec[1] = '{ 4, 1'b0, 4, 12, 1'b0,  -4, 3, 1'b0, 1'b0, 1'b1};
    vec[2] = '{ 1, 1'b1, 2, 10, 1'b0,   1, 0, 1'b1, 1'b0, 1'b1};
    vec[3] = '{ 3, 1'b1, 5, 20, 1'b1,   0, 0, 1'b0, 1'b1, 1'b0};
    vec[4] = '{ 3, 1'b1, 3,  8, 1'b0,   3, 2, 1'b1, 1'b0, 1'b1};

    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // table-driven pulse trains, each from a fresh reset
    for (int i = 0; i < 5; i++) begin
      do_reset();
      dir_in = vec[i].dir;
      enable_n_in = vec[i].en_n;
      repeat (5) @(negedge clk);
      v0 = valid_cnt;
      exp_period = vec[i].per;
      chk_period = 1'b1;
      for (int k = 0; k < vec[i].n; k++) pulse(vec[i].high, vec[i].per - vec[i].high);
      repeat (4) @(negedge clk);
      chk_period = 1'b0;
      check($sformatf("v%0d position", i), position, 32'(vec[i].exp_pos));
      check($sformatf("v%0d valid count", i), 32'(valid_cnt - v0), 32'(vec[i].exp_valids));
      check($sformatf("v%0d err_pulse_width", i), 32'(err_pulse_width), 32'(vec[i].exp_pw));
      check($sformatf("v%0d err_dir_setup", i), 32'(err_dir_setup), 32'd0);
      check($sformatf("v%0d err_step_disabled", i), 32'(err_step_disabled), 32'(vec[i].exp_dis));
      check($sformatf("v%0d moving", i), 32'(moving), 32'(vec[i].exp_mov));
    end
    enable_n_in = 1'b0;

    // direction reversal with legal and violating setup
    do_reset();
    dir_in = 1'b1;
    repeat (5) @(negedge clk);
    repeat (5) pulse(5, 15);
    dir_in = 1'b0;
    repeat (3) @(negedge clk);
    repeat (8) pulse(5, 15);
    repeat (4) @(negedge clk);
    check("reversal position", position, 32'hFFFF_FFFD);
    check("reversal err_dir_setup", 32'(err_dir_setup), 32'd0);
    dir_in = 1'b1;
    @(negedge clk);
    pulse(5, 15);
    repeat (4) @(negedge clk);
    check("late dir err_dir_setup", 32'(err_dir_setup), 32'd1);
    check("late dir position", position, 32'hFFFF_FFFE);

    // short pulse then clear_err
    do_reset();
    dir_in = 1'b1;
    repeat (5) @(negedge clk);
    pulse(2, 10);
    check("short err_pulse_width", 32'(err_pulse_width), 32'd1);
    check("short position", position, 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
    check("cleared err_pulse_width", 32'(err_pulse_width), 32'd0);

    // idle timeout, restart without strobe, clear_pos with a -1 step
    do_reset();
    dir_in = 1'b1;
    repeat (5) @(negedge clk);
    mov_cnt = 0;
    step_in = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (moving === 1'b1) mov_cnt++;
      if (c == 4) step_in = 1'b0;
    end
    check("idle moving cycles", 32'(mov_cnt), 32'd50);
    check("idle moving dropped", 32'(moving), 32'd0);
    v0 = valid_cnt;
    pulse(5, 10);
    check("restart no strobe", 32'(valid_cnt - v0), 32'd0);
    check("restart moving", 32'(moving), 32'd1);
    check("restart position", position, 32'd2);
    dir_in = 1'b0;
    repeat (4) @(negedge clk);
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    clear_pos = 1'b1;
    @(negedge clk);
    clear_pos = 1'b0;
    repeat (2) @(negedge clk);
    step_in = 1'b0;
    repeat (8) @(negedge clk);
    check("clear_pos with step", position, 32'hFFFF_FFFF);

    // reset in the middle of a pulse train
    do_reset();
    dir_in = 1'b1;
    repeat (5) @(negedge clk);
    repeat (7) pulse(5, 15);
    check("pre-reset position", position, 32'd7);
    check("pre-reset step_period", step_period, 32'd20);
    step_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step_in = 1'b0;
    @(negedge clk);
    check_all_zero("mid reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    v0 = valid_cnt;
    repeat (2) pulse(5, 15);
    repeat (4) @(negedge clk);
    check("post-reset strobes", 32'(valid_cnt - v0), 32'd1);
    check("post-reset position", position, 32'd2);
    check("post-reset step_period", step_period, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_dir_decoder.md
Name: step_dir_decoder

Overview:
- Receive-side counterpart of the stepper drive path. Decodes one axis of step/dir/enable signals back into a signed position, a step period and a motion flag.
- Also checks pulse-width and direction-setup timing.
- Uses: in-system monitoring of the step outputs, and loopback verification of the stepper controller.
- One instance per axis. Sits in the same clock domain as the controller; inputs are still treated as asynchronous pins.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on step_in, dir_in and enable_n_in (legal range 2..4).
- MIN_HIGH, 4: minimum legal step high time, in clk cycles.
- DIR_SETUP, 2: number of cycles dir must be stable before a step rising edge.
- IDLE_TIMEOUT, 1000000: cycles without a step rising edge before moving drops.
- POS_W, 32: width of position.
- PERIOD_W, 32: width of the period counter and of step_period.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- step_in  in  1  step pulse; the rising edge is the step.
- dir_in  in  1  direction; 1 = +1 per step, 0 = -1 per step.
- enable_n_in  in  1  active-low driver enable.
- clear_pos  in  1  single-cycle request to zero position.
- clear_err  in  1  single-cycle request to clear the sticky error flags.
- position  out  POS_W  signed step count, two's complement.
- step_period  out  PERIOD_W  cycles between the last two accepted rising edges.
- period_valid  out  1  one-cycle strobe when step_period updates.
- moving  out  1  steps are arriving.
- err_pulse_width  out  1  sticky: a step high time was shorter than MIN_HIGH.
- err_dir_setup  out  1  sticky: dir changed within DIR_SETUP cycles before a step edge.
- err_step_disabled  out  1  sticky: a step edge arrived while disabled.

Behaviour:
- Reset values: every output is 0; the synchronizers, counters and FSM also clear. FSM state goes to WAIT_FIRST. rst has priority over everything.
- Synchronization: s_step, s_dir and s_en are the last stages of the three synchronizers.
- Rising edge (rise) = s_step & ~s_step_d. Falling edge (fall) = ~s_step & s_step_d.
- Latency: position, period_valid and moving update on the clock edge SYNC_STAGES+1 after the first edge that samples step_in=1.
- Accepted step: a rise with s_en=0 (enabled) is counted.
  - position changes by +1 if s_dir=1, otherwise by -1.
  - position wraps modulo 2^POS_W with no saturation.
- Step while disabled: a rise with s_en=1 is not counted, sets err_step_disabled, and does not affect the period logic.
- clear_pos and an accepted step in the same cycle: position becomes +1 or -1, i.e. the clear is applied first, then the step.
- Pulse-width check:
  - A high counter resets on rise and increments (saturating) while s_step=1.
  - On fall, if high count < MIN_HIGH, err_pulse_width is set. The step is still counted.
- Direction-setup check:
  - A stable counter resets whenever s_dir changes and increments (saturating at DIR_SETUP) otherwise.
  - On an accepted rise, if stable count < DIR_SETUP, err_dir_setup is set. The step still counts using the current s_dir.
- Period FSM states: WAIT_FIRST, RUN.
  - WAIT_FIRST: on an accepted rise, clear the period counter, set moving=1 and go to RUN. No period_valid.
  - RUN: the period counter increments every cycle, saturating at all-ones.
  - RUN, accepted rise: step_period takes the period counter value + 1 (saturating), period_valid pulses for one cycle, and the counter clears.
  - RUN, no accepted rise for IDLE_TIMEOUT consecutive cycles: moving=0 and go to WAIT_FIRST.
- Error flags: sticky until clear_err or rst.
  - clear_err together with a new error event in the same cycle: the flag stays 1 (set wins).
- Enable deasserted mid-motion: FSM state and position hold; moving drops only via the timeout.

Optional Feature:
- Macro: STEP_DECODER_SOFT_LIMIT_EN.
- When defined:
  - Adds parameters POS_MIN (default 0) and POS_MAX (default 200000).
  - Adds output limit_hit (1 bit, sticky, cleared by clear_err).
  - limit_hit sets when an accepted step would take position below POS_MIN or above POS_MAX.
  - position still updates, so it mirrors the real motor.
- When undefined: no limit parameters, no limit_hit port, no comparators.

Test Plan:
- Pulse train: 10 rises with dir=1, high 5 cycles, period 20 cycles, enable_n_in=0. Required: position=10; 9 period_valid strobes, each with step_period=20; no error flags.
- Direction reversal: 5 steps with dir=1, then dir=0 held 3 cycles, then 8 steps. Required: position=-3; err_dir_setup=0. Repeat with dir changing 1 cycle before the rise: err_dir_setup=1 and position is still counted.
- Short pulse: a step high for 2 cycles with MIN_HIGH=4. Required: err_pulse_width=1 and position is incremented. Then clear_err: the flag returns to 0.
- Disabled: enable_n_in=1 and 3 steps. Required: position unchanged, err_step_disabled=1, moving=0.
- Idle and same-cycle clear: use IDLE_TIMEOUT=50.
  - After one step, moving drops 50 cycles after the last rise.
  - The next rise gives no period_valid.
  - clear_pos coincident with a dir=0 accepted step gives position=-1.
- Reset mid-motion: assert rst during a pulse train at position=7. Required: all outputs 0 on the next edge; the FSM restarts in WAIT_FIRST.
